// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - request and IF-control bundle between hazard/branch logic and the fetch controller
interface fetch_redirect_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             jal_req;
    logic [31:0]      jal_target;
    logic             br_req;
    logic [31:0]      br_target;
    logic             ld_use_hazard;
    logic             fetch_en;
    logic             control_j;
    logic [31:0]      pc_j;
    logic             flush_ifid;
    logic             flush_idex;
    logic             stall_ifid;
    logic             misalign_err;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] redirect_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output jal_req, jal_target, br_req, br_target, ld_use_hazard,
        input  fetch_en, control_j, pc_j, flush_ifid, flush_idex, stall_ifid,
               misalign_err, ctrl_state, redirect_cnt, stall_cnt
    );

    modport slave (
        input  jal_req, jal_target, br_req, br_target, ld_use_hazard,
        output fetch_en, control_j, pc_j, flush_ifid, flush_idex, stall_ifid,
               misalign_err, ctrl_state, redirect_cnt, stall_cnt
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - IF-stage sequencer: boot delay, launch, JAL/branch redirect arbitration, stalls
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'd64,
    parameter int          BOOT_CYCLES = 4,
    parameter int          CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_redirect_ctrl_if.slave bus
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_REDIR  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
    logic             redir_br_q, redir_br_d;
    logic             fetch_en_q, fetch_en_d;
    logic             control_j_q, control_j_d;
    logic [31:0]      pc_j_q, pc_j_d;
    logic             flush_ifid_q, flush_ifid_d;
    logic             flush_idex_q, flush_idex_d;
    logic             stall_ifid_q, stall_ifid_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             take_br;
    logic             take_jal;
    logic [31:0]      target;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_BOOT;
            boot_cnt_q     <= '0;
            redir_br_q     <= 1'b0;
            fetch_en_q     <= 1'b0;
            control_j_q    <= 1'b0;
            pc_j_q         <= '0;
            flush_ifid_q   <= 1'b0;
            flush_idex_q   <= 1'b0;
            stall_ifid_q   <= 1'b0;
            misalign_q     <= 1'b0;
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            boot_cnt_q     <= boot_cnt_d;
            redir_br_q     <= redir_br_d;
            fetch_en_q     <= fetch_en_d;
            control_j_q    <= control_j_d;
            pc_j_q         <= pc_j_d;
            flush_ifid_q   <= flush_ifid_d;
            flush_idex_q   <= flush_idex_d;
            stall_ifid_q   <= stall_ifid_d;
            misalign_q     <= misalign_d;
            redirect_cnt_q <= redirect_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        boot_cnt_d     = boot_cnt_q;
        redir_br_d     = redir_br_q;
        fetch_en_d     = 1'b1;
        control_j_d    = 1'b0;
        pc_j_d         = pc_j_q;
        flush_ifid_d   = 1'b0;
        flush_idex_d   = 1'b0;
        stall_ifid_d   = 1'b0;
        misalign_d     = misalign_q;
        redirect_cnt_d = redirect_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        take_br        = 1'b0;
        take_jal       = 1'b0;

        case (state_q)
            ST_BOOT: begin
                fetch_en_d = 1'b0;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d     = ST_LAUNCH;
                    control_j_d = 1'b1;
                    pc_j_d      = {RESET_PC[31:2], 2'b00};
                    fetch_en_d  = 1'b1;
                end else begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.br_req) begin
                    take_br = 1'b1;
                end else if (bus.jal_req) begin
                    take_jal = 1'b1;
                end else if (bus.ld_use_hazard) begin
                    fetch_en_d   = 1'b0;
                    stall_ifid_d = 1'b1;
                    flush_idex_d = 1'b1;
                    if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end
            ST_REDIR: begin
                // A branch in EX is older than a JAL already redirected from ID, so it still wins.
                if (bus.br_req && !redir_br_q) take_br = 1'b1;
                else                           state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase

        target = take_br ? bus.br_target : bus.jal_target;
        if (take_br || take_jal) begin
            state_d      = ST_REDIR;
            redir_br_d   = take_br;
            control_j_d  = 1'b1;
            pc_j_d       = {target[31:2], 2'b00};
            flush_ifid_d = 1'b1;
            flush_idex_d = take_br;
            if (target[1:0] != 2'b00) misalign_d = 1'b1;
            if (redirect_cnt_q != {CNT_W{1'b1}}) redirect_cnt_d = redirect_cnt_q + 1'b1;
        end
    end

    assign bus.fetch_en     = fetch_en_q;
    assign bus.control_j    = control_j_q;
    assign bus.pc_j         = pc_j_q;
    assign bus.flush_ifid   = flush_ifid_q;
    assign bus.flush_idex   = flush_idex_q;
    assign bus.stall_ifid   = stall_ifid_q;
    assign bus.misalign_err = misalign_q;
    assign bus.ctrl_state   = state_q;
    assign bus.redirect_cnt = redirect_cnt_q;
    assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - self-checking bench for fetch_redirect_ctrl against a cycle model
module tb_fetch_redirect_ctrl;

    localparam int          BOOT    = 4;
    localparam logic [31:0] RST_PC  = 32'd64;
    localparam int          CMAX    = 65535;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fetch_redirect_ctrl_if #(.CNT_W(16)) bus ();

    fetch_redirect_ctrl #(.RESET_PC(RST_PC), .BOOT_CYCLES(BOOT), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: cycles elapsed since reset release and the kind of redirect issued last edge.
    int          since;
    int          last_kind;   // 0 none, 1 jal, 2 branch
    logic        m_fe, m_cj, m_fi, m_fx, m_st, m_mis;
    logic [31:0] m_pc;
    int          m_state, m_rc, m_sc;

    task automatic model_reset();
        since = 0; last_kind = 0;
        m_fe = 0; m_cj = 0; m_fi = 0; m_fx = 0; m_st = 0; m_mis = 0;
        m_pc = 0; m_state = 0; m_rc = 0; m_sc = 0;
    endtask

    task automatic model_redirect(input logic [31:0] t, input int kind);
        m_cj = 1; m_pc = t & ~32'd3; m_fi = 1; m_fx = (kind == 2);
        m_state = 3; last_kind = kind;
        if (t[1:0] != 2'b00) m_mis = 1;
        if (m_rc < CMAX) m_rc = m_rc + 1;
    endtask

    task automatic model_edge();
        m_cj = 0; m_fi = 0; m_fx = 0; m_st = 0; m_fe = 1;
        if (since < BOOT - 1) begin
            since = since + 1; m_fe = 0; m_state = 0;
        end else if (since == BOOT - 1) begin
            since = since + 1; m_cj = 1; m_pc = RST_PC; m_state = 1;
        end else if (since == BOOT) begin
            since = since + 1; m_state = 2;
        end else begin
            m_state = 2;
            if (last_kind == 1 && bus.br_req) model_redirect(bus.br_target, 2);
            else if (last_kind != 0) last_kind = 0;
            else if (bus.br_req) model_redirect(bus.br_target, 2);
            else if (bus.jal_req) model_redirect(bus.jal_target, 1);
            else if (bus.ld_use_hazard) begin
                m_fe = 0; m_st = 1; m_fx = 1;
                if (m_sc < CMAX) m_sc = m_sc + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        assert (got === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("fetch_en",     32'(bus.fetch_en),     32'(m_fe));
        chk("control_j",    32'(bus.control_j),    32'(m_cj));
        chk("pc_j",         bus.pc_j,              m_pc);
        chk("flush_ifid",   32'(bus.flush_ifid),   32'(m_fi));
        chk("flush_idex",   32'(bus.flush_idex),   32'(m_fx));
        chk("stall_ifid",   32'(bus.stall_ifid),   32'(m_st));
        chk("misalign_err", 32'(bus.misalign_err), 32'(m_mis));
        chk("ctrl_state",   32'(bus.ctrl_state),   32'(m_state));
        chk("redirect_cnt", 32'(bus.redirect_cnt), 32'(m_rc));
        chk("stall_cnt",    32'(bus.stall_cnt),    32'(m_sc));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic j, input logic [31:0] jt, input logic b,
                         input logic [31:0] bt, input logic h);
        bus.jal_req = j; bus.jal_target = jt;
        bus.br_req = b;  bus.br_target = bt;
        bus.ld_use_hazard = h;
    endtask

    task automatic boot_to_run();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < BOOT; i++) begin
            chk("boot_fetch_off", 32'(bus.fetch_en), 32'd0);
            step();
        end
        chk("launch_cj", 32'(bus.control_j), 32'd1);
        chk("launch_pc", bus.pc_j, RST_PC);
        step();
        chk("run_fetch_en", 32'(bus.fetch_en), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b0;

        boot_to_run();

        // Single JAL
        drive(1, 32'd96, 0, 0, 0); step();
        chk("jal_pc", bus.pc_j, 32'd96);
        chk("jal_rc", 32'(bus.redirect_cnt), 32'd1);
        drive(0, 0, 0, 0, 0); step();

        // Branch beats JAL; JAL in the REDIR cycle ignored
        drive(1, 32'd96, 1, 32'd68, 0); step();
        chk("br_pc", bus.pc_j, 32'd68);
        chk("br_flush_idex", 32'(bus.flush_idex), 32'd1);
        drive(1, 32'd96, 0, 0, 0); step();
        chk("redir_jal_ignored", 32'(bus.control_j), 32'd0);
        drive(0, 0, 0, 0, 0); step();

        // JAL followed by branch in REDIR
        drive(1, 32'd96, 0, 0, 0); step();
        drive(0, 0, 1, 32'd104, 0); step();
        chk("jal_then_br_pc", bus.pc_j, 32'd104);
        chk("jal_then_br_cj", 32'(bus.control_j), 32'd1);
        drive(0, 0, 0, 0, 0); step(); step();

        // Load-use stall for 3 cycles, then branch overriding a stall
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1); step();
            chk("stall_ifid", 32'(bus.stall_ifid), 32'd1);
        end
        chk("stall_cnt3", 32'(bus.stall_cnt), 32'd3);
        drive(0, 0, 1, 32'd200, 1); step();
        chk("br_over_stall", 32'(bus.control_j), 32'd1);
        drive(0, 0, 0, 0, 0); step();

        // Misaligned JAL target
        drive(1, 32'd98, 0, 0, 0); step();
        chk("mis_pc", bus.pc_j, 32'd96);
        chk("mis_err", 32'(bus.misalign_err), 32'd1);
        drive(0, 0, 0, 0, 0); step();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 3) == 0), {$urandom_range(0, 255), 2'($urandom_range(0, 7) == 0 ? 2 : 0)},
                  ($urandom_range(0, 4) == 0), {$urandom_range(0, 255), 2'b00},
                  ($urandom_range(0, 3) == 0));
            step();
        end

        // Asynchronous reset while in REDIR
        drive(0, 0, 0, 0, 0); step(); step();
        drive(1, 32'd96, 0, 0, 0); step();
        chk("in_redir", 32'(bus.ctrl_state), 32'd3);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_state", 32'(bus.ctrl_state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        boot_to_run();

        // Stall counter saturation
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < CMAX + 4; i++) step();
        chk("stall_sat", 32'(bus.stall_cnt), 32'h0000_FFFF);
        drive(0, 0, 0, 0, 0); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
